instruction_fetch_queue: RTL

//  Fetch front end that feeds the IF/ID pipe register. Issues sequential word fetches to

---
 rtl/instruction_fetch_queue_pkg.sv | 26 ++
 rtl/instruction_fetch_queue_fetch_fifo.sv | 89 ++++++++
 rtl/instruction_fetch_queue.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_queue_pkg
//  Shared constants and types for the instruction fetch front end.
//  - INSTR_W / PC_INC / NOP_INSTR / RESET_PC_DEFAULT : fetch datapath constants
//  - fetch_entry_t : one queue entry, the fetched word plus its PC+4
//  - pc_plus_inc() : sequential next-PC helper (wraps modulo 2^32)
// -----------------------------------------------------------------------------
package instruction_fetch_queue_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] inst;
        logic [INSTR_W-1:0] pc_next;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [INSTR_W-1:0] pc_plus_inc(input logic [INSTR_W-1:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/instruction_fetch_queue_fetch_fifo.sv
// -----------------------------------------------------------------------------
// instruction_fetch_queue_fetch_fifo
//  Synchronous FIFO holding fetched entries. The head is read straight out of
//  the storage array, so a word pushed in cycle N is visible at the head in
//  cycle N+1. Flush has priority over push and pop.
//  Ports:
//   clk, rst      clock / synchronous active-high reset
//   push, push_data  write one entry
//   pop           consume the head entry
//   flush         empty the FIFO (drops any same-cycle push/pop)
//   head_data     current head entry (undefined when empty)
//   full, empty, count  occupancy status
// -----------------------------------------------------------------------------
module instruction_fetch_queue_fetch_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty && !flush;
        // A push into a full FIFO is accepted only when the head leaves in the
        // same cycle; the slot being overwritten is the one being consumed.
        do_push  = push && (!full || do_pop) && !flush;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/instruction_fetch_queue.sv
// -----------------------------------------------------------------------------
// instruction_fetch_queue
//  Fetch front end feeding the IF/ID register. Issues sequential word fetches
//  over a valid/ready request channel, accepts in-order one-cycle response
//  pulses, queues {word, PC+4} and presents the head to decode. Honours the
//  decode hold and flushes on redirect.
//  Ports:
//   clk, rst                        clock / synchronous active-high reset
//   imem_req_valid/ready/addr       fetch request channel (addr = fetch PC)
//   imem_resp_valid/data            in-order response pulse and word
//   redirect_valid/redirect_pc      taken branch/jump: flush and refetch
//   hold                            decode stall, head is not consumed
//   inst_valid/inst/inst_pc_next    queue head presented to decode
// -----------------------------------------------------------------------------
module instruction_fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [31:0]        imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               hold,
    output logic               inst_valid,
    output logic [INSTR_W-1:0] inst,
    output logic [31:0]        inst_pc_next
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUT + 1);

    logic [31:0]      fetch_pc_q,  fetch_pc_d;
    logic [31:0]      resp_pc_q,   resp_pc_d;
    logic [OUT_W-1:0] in_flight_q, in_flight_d;
    logic [OUT_W-1:0] discard_q,   discard_d;

    logic             resp_ok;
    logic             req_fire;
    logic             credit_ok;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;

    // A response with nothing outstanding is illegal and simply ignored.
    assign resp_ok  = imem_resp_valid && (in_flight_q != '0);
    assign req_fire = imem_req_valid && imem_req_ready;

    // Every live (non-discarded) outstanding request owns a future queue slot.
    assign credit_ok = (int'(fifo_count) + int'(in_flight_q) - int'(discard_q)) < DEPTH;

    assign imem_req_valid = !rst && !redirect_valid
                          && (in_flight_q < OUT_W'(MAX_OUT)) && credit_ok;
    assign imem_req_addr  = fetch_pc_q;

    assign inst_valid   = !fifo_empty && !rst;
    assign inst         = inst_valid ? head_entry.inst    : NOP_INSTR;
    assign inst_pc_next = inst_valid ? head_entry.pc_next : 32'h0;
    assign fifo_pop     = inst_valid && !hold;

    assign push_entry.inst    = imem_resp_data;
    assign push_entry.pc_next = pc_plus_inc(resp_pc_q);

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        resp_pc_d   = resp_pc_q;
        in_flight_d = in_flight_q;
        discard_d   = discard_q;
        fifo_push   = 1'b0;

        if (resp_ok) begin
            in_flight_d = in_flight_q - OUT_W'(1);
        end

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            // Everything still outstanding after this cycle belongs to the old
            // path; no request is issued here, so that is exactly in_flight_d.
            discard_d  = in_flight_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d  = pc_plus_inc(fetch_pc_q);
                in_flight_d = in_flight_d + OUT_W'(1);
            end
            if (resp_ok) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - OUT_W'(1);
                end else begin
                    fifo_push = 1'b1;
                    resp_pc_d = pc_plus_inc(resp_pc_q);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            resp_pc_q   <= RESET_PC;
            in_flight_q <= '0;
            discard_q   <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            resp_pc_q   <= resp_pc_d;
            in_flight_q <= in_flight_d;
            discard_q   <= discard_d;
        end
    end

    instruction_fetch_queue_fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(fifo_push && fifo_full && !fifo_pop));

    a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
        !(imem_resp_valid && (in_flight_q == '0)));

endmodule
